// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and access sequencer in front of
// a byte-addressed data memory with synchronous reads.
//
// Requester 0 is the CPU load/store unit and requester 1 is the loader/debug
// port. Each byte, half or word request becomes one word-aligned memory access
// with byte enables. Load data is lane-extracted and then sign- or
// zero-extended. Responses use a valid/ready handshake per requester.
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word requests return rsp_err and make no access
//   undefined : misaligned requests are forced aligned and proceed normally
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (ready is combinational)
//   req_we, req_unsigned  store select, load zero-extend (per requester)
//   req_mode              2 bits per requester: 00 byte, 01 half, 10 word, 11 reserved
//   req_addr, req_wdata   byte address and right-aligned store data (per requester)
//   rsp_valid/rsp_ready   per-requester response handshake
//   rsp_rdata, rsp_err    load result (0 for stores/errors), error flag
//   mem_addr/wdata/be     registered word-aligned access, lane-placed data, enables
//   mem_we, mem_re        one-cycle write/read strobes
//   mem_rdata             read data, valid the cycle after mem_re
module dmem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [1:0]              req_unsigned,
  input  logic [3:0]              req_mode,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*WIDTH-1:0]      req_wdata,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [WIDTH-1:0]        rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]        mem_wdata,
  output logic [WIDTH/8-1:0]      mem_be,
  output logic                    mem_we,
  output logic                    mem_re,
  input  logic [WIDTH-1:0]        mem_rdata
);

  localparam int NB = WIDTH / 8;
  localparam int LB = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    RESP
  } state_e;

  state_e                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    owner_q, owner_d;
  logic                    we_q, we_d;
  logic                    uns_q, uns_d;
  logic [1:0]              mode_q, mode_d;
  logic [LB-1:0]           lane_q, lane_d;
  logic [1:0]              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]        rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]        mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]           mem_be_q, mem_be_d;
  logic                    mem_we_q, mem_we_d;
  logic                    mem_re_q, mem_re_d;

  logic                    win;
  logic                    sel_we;
  logic                    sel_uns;
  logic                    sel_err;
  logic [1:0]              sel_mode;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [ADDR_WIDTH-1:0]   addr_fix;
  logic [WIDTH-1:0]        sel_wdata;
  logic [WIDTH-1:0]        wdata_place;
  logic [NB-1:0]           be_place;
  logic [7:0]              byte_v;
  logic [15:0]             half_v;
  logic [WIDTH-1:0]        load_ext;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic                    misalign;
`endif

  // Arbitration and request decode. With both valid, the requester that did
  // not win last time gets the grant; otherwise the sole valid one wins.
  always_comb begin
    win = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && (req_valid != 2'b00)) begin
      req_ready[win] = 1'b1;
    end

    sel_we    = req_we[win];
    sel_uns   = req_unsigned[win];
    sel_mode  = win ? req_mode[3:2] : req_mode[1:0];
    sel_addr  = win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
    sel_wdata = win ? req_wdata[2*WIDTH-1:WIDTH] : req_wdata[WIDTH-1:0];

`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = ((sel_mode == 2'b01) && sel_addr[0]) ||
               ((sel_mode == 2'b10) && (sel_addr[LB-1:0] != '0));
    sel_err  = (sel_mode == 2'b11) || misalign;
    addr_fix = sel_addr;
`else
    // Misaligned requests are silently aligned; only the reserved mode errors.
    sel_err  = (sel_mode == 2'b11);
    addr_fix = sel_addr;
    if (sel_mode == 2'b01) begin
      addr_fix[0] = 1'b0;
    end else if (sel_mode == 2'b10) begin
      addr_fix[LB-1:0] = '0;
    end
`endif

    case (sel_mode)
      2'b00: begin
        be_place    = NB'(1) << addr_fix[LB-1:0];
        wdata_place = {NB{sel_wdata[7:0]}};
      end
      2'b01: begin
        be_place    = NB'(3) << {addr_fix[LB-1:1], 1'b0};
        wdata_place = {(NB/2){sel_wdata[15:0]}};
      end
      default: begin
        be_place    = '1;
        wdata_place = sel_wdata;
      end
    endcase
  end

  // Lane extraction of the returned word using the latched request fields.
  always_comb begin
    byte_v = mem_rdata[{lane_q, 3'b000} +: 8];
    half_v = mem_rdata[{lane_q[LB-1:1], 4'b0000} +: 16];
    case (mode_q)
      2'b00:   load_ext = uns_q ? {{(WIDTH-8){1'b0}}, byte_v}
                                : {{(WIDTH-8){byte_v[7]}}, byte_v};
      2'b01:   load_ext = uns_q ? {{(WIDTH-16){1'b0}}, half_v}
                                : {{(WIDTH-16){half_v[15]}}, half_v};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    uns_d        = uns_q;
    mode_d       = mode_q;
    lane_d       = lane_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    mem_we_d     = 1'b0;
    mem_re_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          owner_d      = win;
          last_grant_d = win;
          we_d         = sel_we;
          uns_d        = sel_uns;
          mode_d       = sel_mode;
          lane_d       = addr_fix[LB-1:0];
          if (sel_err) begin
            rsp_valid_d = win ? 2'b10 : 2'b01;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = RESP;
          end else begin
            // Memory-side outputs are registered here so the strobe lands
            // in the ACCESS cycle.
            mem_addr_d  = {addr_fix[ADDR_WIDTH-1:LB], {LB{1'b0}}};
            mem_be_d    = be_place;
            mem_wdata_d = sel_we ? wdata_place : '0;
            mem_we_d    = sel_we;
            mem_re_d    = ~sel_we;
            state_d     = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = load_ext;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = '0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      mode_q       <= '0;
      lane_q       <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      uns_q        <= uns_d;
      mode_q       <= mode_d;
      lane_q       <= lane_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a small behavioural memory model.
module tb_dmem_arbiter;
  localparam int W  = 32;
  localparam int AW = 17;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid, req_ready, req_we, req_unsigned;
  logic [3:0]        req_mode;
  logic [2*AW-1:0]   req_addr;
  logic [2*W-1:0]    req_wdata;
  logic [1:0]        rsp_valid, rsp_ready;
  logic [W-1:0]      rsp_rdata;
  logic              rsp_err;
  logic [AW-1:0]     mem_addr;
  logic [W-1:0]      mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_we, mem_re;
  logic [W-1:0]      mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  dmem_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_unsigned(req_unsigned), .req_mode(req_mode), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  // Synchronous-read memory with byte-lane writes.
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    if (mem_re) mem_rdata <= mem[mem_addr[7:2]];
  end

  function automatic logic [1:0] oh(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic uns, input logic [1:0] mode,
                         input logic [AW-1:0] addr, input logic [31:0] wd);
    req_valid[i]         = 1'b1;
    req_we[i]            = we;
    req_unsigned[i]      = uns;
    req_mode[2*i +: 2]   = mode;
    req_addr[AW*i +: AW] = addr;
    req_wdata[W*i +: W]  = wd;
  endtask

  task automatic finish_rsp;
    rsp_ready = 2'b11;
    tick;
    rsp_ready = 2'b00;
    check("rsp_cleared", 32'(rsp_valid), 32'h0);
  endtask

  task automatic store(input int i, input logic [1:0] mode, input logic [AW-1:0] addr,
                       input logic [31:0] wd, input logic [AW-1:0] exp_addr,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd);
    set_req(i, 1'b1, 1'b0, mode, addr, wd);
    #1;
    check("st_ready", 32'(req_ready), 32'(oh(i)));
    tick;
    req_valid = 2'b00;
    check("st_we", 32'(mem_we), 32'h1);
    check("st_re", 32'(mem_re), 32'h0);
    check("st_addr", 32'(mem_addr), 32'(exp_addr));
    check("st_be", 32'(mem_be), 32'(exp_be));
    check("st_wdata", mem_wdata, exp_wd);
    tick;
    check("st_we_drop", 32'(mem_we), 32'h0);
    check("st_rsp_valid", 32'(rsp_valid), 32'(oh(i)));
    check("st_rsp_rdata", rsp_rdata, 32'h0);
    check("st_rsp_err", 32'(rsp_err), 32'h0);
    finish_rsp;
  endtask

  task automatic load(input int i, input logic uns, input logic [1:0] mode, input logic [AW-1:0] addr,
                      input logic [AW-1:0] exp_addr, input logic [31:0] exp_d);
    set_req(i, 1'b0, uns, mode, addr, 32'h0);
    #1;
    check("ld_ready", 32'(req_ready), 32'(oh(i)));
    tick;
    req_valid = 2'b00;
    check("ld_re", 32'(mem_re), 32'h1);
    check("ld_we", 32'(mem_we), 32'h0);
    check("ld_addr", 32'(mem_addr), 32'(exp_addr));
    tick;
    check("ld_re_drop", 32'(mem_re), 32'h0);
    check("ld_no_rsp_yet", 32'(rsp_valid), 32'h0);
    tick;
    check("ld_rsp_valid", 32'(rsp_valid), 32'(oh(i)));
    check("ld_rdata", rsp_rdata, exp_d);
    check("ld_err", 32'(rsp_err), 32'h0);
    finish_rsp;
  endtask

  task automatic err_req(input int i, input logic [1:0] mode, input logic [AW-1:0] addr);
    set_req(i, 1'b0, 1'b0, mode, addr, 32'h0);
    #1;
    check("er_ready", 32'(req_ready), 32'(oh(i)));
    tick;
    req_valid = 2'b00;
    check("er_rsp_valid", 32'(rsp_valid), 32'(oh(i)));
    check("er_err", 32'(rsp_err), 32'h1);
    check("er_rdata", rsp_rdata, 32'h0);
    check("er_no_re", 32'(mem_re), 32'h0);
    check("er_no_we", 32'(mem_we), 32'h0);
    finish_rsp;
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = '0;
    req_we       = '0;
    req_unsigned = '0;
    req_mode     = '0;
    req_addr     = '0;
    req_wdata    = '0;
    rsp_ready    = '0;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_be", 32'(mem_be), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_re", 32'(mem_re), 32'h0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;

    // Word store then word load round trip.
    store(0, 2'b10, 17'h10, 32'hDEADBEEF, 17'h10, 4'b1111, 32'hDEADBEEF);
    load(0, 1'b0, 2'b10, 17'h10, 17'h10, 32'hDEADBEEF);

    // Byte/half extraction from 0x80FF7F01.
    store(0, 2'b10, 17'h10, 32'h80FF7F01, 17'h10, 4'b1111, 32'h80FF7F01);
    load(0, 1'b0, 2'b00, 17'h13, 17'h10, 32'hFFFFFF80);
    load(0, 1'b1, 2'b00, 17'h13, 17'h10, 32'h00000080);
    load(1, 1'b0, 2'b01, 17'h12, 17'h10, 32'hFFFF80FF);
    load(0, 1'b0, 2'b00, 17'h11, 17'h10, 32'h0000007F);
    load(1, 1'b1, 2'b01, 17'h10, 17'h10, 32'h00007F01);

    // Sub-word stores.
    store(1, 2'b01, 17'h22, 32'h0000A5A5, 17'h20, 4'b1100, 32'hA5A5A5A5);
    store(0, 2'b00, 17'h21, 32'h0000005A, 17'h20, 4'b0010, 32'h5A5A5A5A);
    load(1, 1'b1, 2'b01, 17'h22, 17'h20, 32'h0000A5A5);

    // Misaligned requests.
`ifdef DMEM_MISALIGN_TRAP_EN
    err_req(0, 2'b10, 17'h12);
    err_req(1, 2'b01, 17'h13);
`else
    load(0, 1'b0, 2'b10, 17'h12, 17'h10, 32'h80FF7F01);
    load(1, 1'b0, 2'b01, 17'h13, 17'h10, 32'hFFFF80FF);
`endif
    // Reserved mode is an error in every build.
    err_req(1, 2'b11, 17'h40);

    // Both requesters valid continuously from reset: grants alternate.
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 2'b10, 17'h10, 32'h0);
    set_req(1, 1'b0, 1'b1, 2'b01, 17'h22, 32'h0);
    rsp_ready = 2'b11;
    #1;
    check("rr_ready_in_reset", 32'(req_ready), 32'h0);
    tick;
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 6 && req_ready == 2'b00; c++) tick;
      check("rr_grant", 32'(req_ready), 32'(oh(k % 2)));
      tick;
      for (int c = 0; c < 6 && rsp_valid == 2'b00; c++) tick;
      check("rr_rsp_owner", 32'(rsp_valid), 32'(oh(k % 2)));
      check("rr_rdata", rsp_rdata, (k % 2 == 0) ? 32'h80FF7F01 : 32'h0000A5A5);
      tick;
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    tick;

    // Reset during CAPTURE aborts; req1 is then accepted in the first IDLE cycle.
    set_req(0, 1'b0, 1'b0, 2'b10, 17'h10, 32'h0);
    #1;
    tick;
    req_valid = 2'b00;
    tick;
    set_req(1, 1'b1, 1'b0, 2'b00, 17'h33, 32'h000000C3);
    #1;
    check("busy_not_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    check("abort_mem_re", 32'(mem_re), 32'h0);
    check("abort_mem_addr", 32'(mem_addr), 32'h0);
    check("abort_mem_be", 32'(mem_be), 32'h0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    check("abort_req_ready", 32'(req_ready), 32'h0);
    #2;
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'h2);
    tick;
    req_valid = 2'b00;
    check("post_rst_we", 32'(mem_we), 32'h1);
    check("post_rst_be", 32'(mem_be), 32'h8);
    check("post_rst_addr", 32'(mem_addr), 32'h30);
    check("post_rst_wdata", mem_wdata, 32'hC3C3C3C3);
    tick;
    check("post_rst_rsp", 32'(rsp_valid), 32'h2);
    finish_rsp;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the byte-addressed data memory. It arbitrates between requester 0 (CPU load/store unit) and requester 1 (loader/debug port) round-robin, with a valid/ready request and response handshake per requester. It converts each byte, half or word request into a word-aligned memory access with byte enables, and returns load data lane-extracted and sign- or zero-extended. It sits between the load/store path and the memory array, which has synchronous reads.

## Interface
- `WIDTH`, 32, data width; byte lanes = WIDTH/8 = 4
- `ADDR_WIDTH`, 17, byte-address width (2**17-byte memory)
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  [1:0]  request valid, bit i = requester i
- `req_ready`  out  [1:0]  request accepted this cycle
- `req_we`  in  [1:0]  1 = store, 0 = load
- `req_unsigned`  in  [1:0]  load zero-extend
- `req_mode`  in  [3:0]  2 bits per requester: 00 byte, 01 half, 10 word, 11 reserved
- `req_addr`  in  [2*ADDR_WIDTH-1:0]  byte address per requester
- `req_wdata`  in  [2*WIDTH-1:0]  store data, right-aligned
- `rsp_valid`  out  [1:0]  response valid
- `rsp_ready`  in  [1:0]  response consumed
- `rsp_rdata`  out  WIDTH  load result (0 for stores and errors)
- `rsp_err`  out  1  misaligned or reserved-mode request
- `mem_addr`  out  ADDR_WIDTH  word-aligned byte address, bits [1:0] = 0
- `mem_wdata`  out  WIDTH  lane-placed write data
- `mem_be`  out  4  byte enables
- `mem_we`, `mem_re`  out  1  write / read strobe, one cycle each
- `mem_rdata`  in  WIDTH  read data, valid the cycle after `mem_re`

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE
  - Winner = sole valid requester. If both are valid, the winner is the requester not in `last_grant`.
  - `req_ready[winner]` = 1, combinational. The loser's ready = 0.
  - On handshake, latch the request, set `last_grant` = winner, go to ACCESS. Error requests go straight to RESP with `rsp_err` = 1.
- ACCESS
  - Drive `mem_addr` = {addr[AW-1:2], 2'b00}, `mem_be`, `mem_we` or `mem_re`.
  - Store: go to RESP. Load: go to CAPTURE.
- CAPTURE: register the extracted `mem_rdata`, then go to RESP.
- RESP: `rsp_valid[owner]` = 1 and held until `rsp_ready[owner]`, then go to IDLE.
- Byte enables
  - Byte: be = 1 << addr[1:0]; wdata[7:0] replicated to all lanes.
  - Half: be = addr[1] ? 1100 : 0011; wdata[15:0] replicated.
  - Word: be = 1111.
- Load extraction
  - Select lane by addr[1:0] (half by addr[1]).
  - Sign-extend from bit 7 or bit 15 unless `req_unsigned`. Word loads pass through.
- Errors
  - Mode 11 is always an error.
  - Misalignment: half with addr[0] = 1, or word with addr[1:0] != 0; handling per Configuration.
  - An error never asserts `mem_we`/`mem_re`.
- `last_grant` resets to 1, so requester 0 wins the first tie.
- A requester holds its request stable while valid and not ready. Any field change before acceptance is legal and is re-sampled.

## Timing
- Accept at cycle N.
  - Load: `mem_re` at N+1, `rsp_valid` at N+3.
  - Store: `mem_we` at N+1, `rsp_valid` at N+2.
  - Error: `rsp_valid` at N+1.
- Response handshake at cycle M means the next accept is possible at M+1. Peak throughput is one load per 4 cycles.
- `mem_*` outputs are registered; strobes high for exactly one cycle.
- Reset values, all outputs: `req_ready` 0, `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0, `mem_addr` 0, `mem_wdata` 0, `mem_be` 0, `mem_we` 0, `mem_re` 0; FSM = IDLE.
- Reset asserted mid-transaction aborts immediately. Strobes drop asynchronously, no response is issued, and the pending request is lost.
- A request arriving while busy waits with ready = 0. Arbitration is re-evaluated only in IDLE.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined: misaligned half/word requests return `rsp_err` = 1 at N+1 with no memory access.
- Not defined: misaligned requests are forced aligned (half clears addr[0], word clears addr[1:0]), proceed normally, and `rsp_err` stays 0. Mode 11 is still an error.

## Test plan
- Store word 0xDEADBEEF @0x10 from req0, then load word @0x10: `mem_be` = 1111, `mem_we` at N+1; load returns 0xDEADBEEF at N+3.
- Load byte @0x13 signed, then unsigned, with memory word 0x80FF7F01: results 0xFFFFFF80, then 0x00000080.
- Store half 0xA5A5 @0x22: `mem_addr` = 0x20, `mem_be` = 1100, `mem_wdata` = 0xA5A5A5A5.
- Both valid continuously from reset: grants alternate 0, 1, 0, 1; each `rsp_valid` goes only to its owner.
- Word load @0x12 with trap enabled: `rsp_err` = 1 at N+1, no `mem_re`. Without the macro: `mem_addr` = 0x10, `rsp_err` = 0.
- Deassert `rst_n` in CAPTURE: all outputs 0 at once; after release, a req1 request is accepted in the first IDLE cycle.
